// File: rtl/id_pipe_stage.sv
// ID stage: decodes an RV32I/Zicsr instruction, issues register/CSR reads and
// holds decoded results in a 2-entry (main + skid) valid/ready buffer toward EX.
module id_pipe_stage #(
    parameter int XLEN           = 32,
    parameter int ADDR_W         = 32,
    parameter int REG_AW         = 5,
    parameter int CSR_AW         = 12,
    parameter bit LOAD_INTERLOCK = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [31:0]       ins_i,
    input  logic [ADDR_W-1:0] ins_addr_i,
    output logic [REG_AW-1:0] reg1_rd_addr_o,
    output logic [REG_AW-1:0] reg2_rd_addr_o,
    input  logic [XLEN-1:0]   reg1_rd_data_i,
    input  logic [XLEN-1:0]   reg2_rd_data_i,
    output logic [CSR_AW-1:0] csr_rd_addr_o,
    input  logic [XLEN-1:0]   csr_rd_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [31:0]       ins_o,
    output logic [ADDR_W-1:0] ins_addr_o,
    output logic [6:0]        opcode_o,
    output logic [2:0]        funct3_o,
    output logic [6:0]        funct7_o,
    output logic [REG_AW-1:0] rd_o,
    output logic [XLEN-1:0]   rs1_data_o,
    output logic [XLEN-1:0]   rs2_data_o,
    output logic [XLEN-1:0]   csr_rd_data_o,
    output logic [XLEN-1:0]   imm_o,
    output logic [CSR_AW-1:0] csr_addr_o,
    output logic [XLEN-1:0]   csr_zimm_o,
    output logic              mem_rd_req_o,
    output logic [ADDR_W-1:0] mem_rd_addr_o,
    output logic              hazard_stall_o
);

    typedef struct packed {
        logic [31:0]       ins;
        logic [ADDR_W-1:0] addr;
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   rs1;
        logic [XLEN-1:0]   rs2;
        logic [XLEN-1:0]   csr;
        logic [XLEN-1:0]   imm;
        logic [ADDR_W-1:0] mem_addr;
        logic              is_load;
    } entry_t;

    entry_t main_q, skid_q, dec;
    logic   main_v, skid_v;

    logic [6:0]        op;
    logic [2:0]        f3;
    logic [31:0]       imm32;
    logic [XLEN-1:0]   sum;
    logic              rs1_used, rs2_used;
    logic              hit_main, hit_skid, hazard;
    logic              accept, consume;
    logic [REG_AW-1:0] rs1_idx, rs2_idx;

    assign op      = ins_i[6:0];
    assign f3      = ins_i[14:12];
    assign rs1_idx = REG_AW'(ins_i[19:15]);
    assign rs2_idx = REG_AW'(ins_i[24:20]);

    always_comb begin
        imm32 = '0;
        case (op)
            7'h03, 7'h13, 7'h67, 7'h73: imm32 = {{20{ins_i[31]}}, ins_i[31:20]};
            7'h23: imm32 = {{20{ins_i[31]}}, ins_i[31:25], ins_i[11:7]};
            7'h63: imm32 = {{19{ins_i[31]}}, ins_i[31], ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0};
            7'h37, 7'h17: imm32 = {ins_i[31:12], 12'h000};
            7'h6F: imm32 = {{11{ins_i[31]}}, ins_i[31], ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (op)
            7'h03, 7'h13, 7'h67: rs1_used = 1'b1;
            7'h23, 7'h33, 7'h63: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            7'h73: rs1_used = !f3[2] && (f3 != 3'd0);
            default: ;
        endcase
    end

    always_comb begin
        dec          = '0;
        dec.ins      = ins_i;
        dec.addr     = ins_addr_i;
        dec.imm      = XLEN'($signed(imm32));
        dec.rs1      = reg1_rd_data_i;
        dec.rs2      = reg2_rd_data_i;
        dec.csr      = csr_rd_data_i;
        dec.is_load  = (op == 7'h03);
        if (op == 7'h23 || op == 7'h63 || (op == 7'h73 && f3 == 3'd0))
            dec.rd = '0;
        else
            dec.rd = REG_AW'(ins_i[11:7]);
        sum          = reg1_rd_data_i + XLEN'($signed(imm32));
        dec.mem_addr = ADDR_W'(sum);
    end

    // A buffered load blocks any incoming instruction that reads its rd.
    always_comb begin
        hit_main = main_v && main_q.is_load && (main_q.rd != '0) &&
                   ((rs1_used && main_q.rd == rs1_idx) || (rs2_used && main_q.rd == rs2_idx));
        hit_skid = skid_v && skid_q.is_load && (skid_q.rd != '0) &&
                   ((rs1_used && skid_q.rd == rs1_idx) || (rs2_used && skid_q.rd == rs2_idx));
        hazard   = LOAD_INTERLOCK && in_valid_i && (hit_main || hit_skid);
    end

    assign in_ready_o     = !skid_v && !hazard && !flush_i;
    assign hazard_stall_o = hazard;
    assign accept         = in_valid_i && in_ready_o;
    assign consume        = main_v && out_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (flush_i) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (consume) begin
            if (skid_v) begin
                main_q <= skid_q;
                skid_v <= 1'b0;
            end else if (accept) begin
                main_q <= dec;
            end else begin
                main_v <= 1'b0;
            end
        end else if (accept) begin
            if (!main_v) begin
                main_q <= dec;
                main_v <= 1'b1;
            end else begin
                skid_q <= dec;
                skid_v <= 1'b1;
            end
        end
    end

    assign reg1_rd_addr_o = rs1_idx;
    assign reg2_rd_addr_o = rs2_idx;
    assign csr_rd_addr_o  = CSR_AW'(ins_i[31:20]);

    assign out_valid_o    = main_v;
    assign ins_o          = main_q.ins;
    assign ins_addr_o     = main_q.addr;
    assign opcode_o       = main_q.ins[6:0];
    assign funct3_o       = main_q.ins[14:12];
    assign funct7_o       = main_q.ins[31:25];
    assign rd_o           = main_q.rd;
    assign rs1_data_o     = main_q.rs1;
    assign rs2_data_o     = main_q.rs2;
    assign csr_rd_data_o  = main_q.csr;
    assign imm_o          = main_q.imm;
    assign csr_addr_o     = CSR_AW'(main_q.ins[31:20]);
    assign csr_zimm_o     = XLEN'(main_q.ins[19:15]);
    assign mem_rd_req_o   = main_v && main_q.is_load;
    assign mem_rd_addr_o  = main_q.mem_addr;

endmodule

// File: tb/tb_id_pipe_stage.sv
// Bench for id_pipe_stage: directed scenarios then random traffic, checked
// against a queue-based model of the two-entry buffer.
module tb_id_pipe_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush_i, in_valid_i, out_ready_i;
    logic [31:0] ins_i, ins_addr_i, reg1_rd_data_i, reg2_rd_data_i, csr_rd_data_i;

    logic        in_ready_o, out_valid_o, mem_rd_req_o, hazard_stall_o;
    logic [4:0]  reg1_rd_addr_o, reg2_rd_addr_o, rd_o;
    logic [11:0] csr_rd_addr_o, csr_addr_o;
    logic [31:0] ins_o, ins_addr_o, rs1_data_o, rs2_data_o, csr_rd_data_o, imm_o, csr_zimm_o, mem_rd_addr_o;
    logic [6:0]  opcode_o, funct7_o;
    logic [2:0]  funct3_o;

    logic        n_in_ready_o, n_out_valid_o, n_mem_rd_req_o, n_hazard_stall_o;
    logic [4:0]  n_reg1_rd_addr_o, n_reg2_rd_addr_o, n_rd_o;
    logic [11:0] n_csr_rd_addr_o, n_csr_addr_o;
    logic [31:0] n_ins_o, n_ins_addr_o, n_rs1_data_o, n_rs2_data_o, n_csr_rd_data_o, n_imm_o, n_csr_zimm_o, n_mem_rd_addr_o;
    logic [6:0]  n_opcode_o, n_funct7_o;
    logic [2:0]  n_funct3_o;

    always #5 clk = ~clk;

    id_pipe_stage #(.LOAD_INTERLOCK(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .ins_i(ins_i), .ins_addr_i(ins_addr_i), .reg1_rd_addr_o(reg1_rd_addr_o), .reg2_rd_addr_o(reg2_rd_addr_o),
        .reg1_rd_data_i(reg1_rd_data_i), .reg2_rd_data_i(reg2_rd_data_i), .csr_rd_addr_o(csr_rd_addr_o),
        .csr_rd_data_i(csr_rd_data_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .ins_o(ins_o),
        .ins_addr_o(ins_addr_o), .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7_o(funct7_o), .rd_o(rd_o),
        .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .csr_rd_data_o(csr_rd_data_o), .imm_o(imm_o),
        .csr_addr_o(csr_addr_o), .csr_zimm_o(csr_zimm_o), .mem_rd_req_o(mem_rd_req_o),
        .mem_rd_addr_o(mem_rd_addr_o), .hazard_stall_o(hazard_stall_o)
    );

    id_pipe_stage #(.LOAD_INTERLOCK(1'b0)) dut_nl (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(n_in_ready_o),
        .ins_i(ins_i), .ins_addr_i(ins_addr_i), .reg1_rd_addr_o(n_reg1_rd_addr_o), .reg2_rd_addr_o(n_reg2_rd_addr_o),
        .reg1_rd_data_i(reg1_rd_data_i), .reg2_rd_data_i(reg2_rd_data_i), .csr_rd_addr_o(n_csr_rd_addr_o),
        .csr_rd_data_i(csr_rd_data_i), .out_valid_o(n_out_valid_o), .out_ready_i(out_ready_i), .ins_o(n_ins_o),
        .ins_addr_o(n_ins_addr_o), .opcode_o(n_opcode_o), .funct3_o(n_funct3_o), .funct7_o(n_funct7_o), .rd_o(n_rd_o),
        .rs1_data_o(n_rs1_data_o), .rs2_data_o(n_rs2_data_o), .csr_rd_data_o(n_csr_rd_data_o), .imm_o(n_imm_o),
        .csr_addr_o(n_csr_addr_o), .csr_zimm_o(n_csr_zimm_o), .mem_rd_req_o(n_mem_rd_req_o),
        .mem_rd_addr_o(n_mem_rd_addr_o), .hazard_stall_o(n_hazard_stall_o)
    );

    typedef struct {
        logic [31:0] ins, addr, r1, r2, c, imm, maddr;
        logic [4:0]  rd;
        logic        load;
    } exp_t;

    exp_t q[$];
    int   n0;
    int   pass_cnt = 0, fail_cnt = 0, total = 0;
    logic last_rdy, last_hz, last_rdy0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic uses_rs1(input logic [31:0] ins);
        logic [2:0] f3 = ins[14:12];
        case (ins[6:0])
            7'h03, 7'h13, 7'h23, 7'h33, 7'h63, 7'h67: return 1'b1;
            7'h73: return (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd3);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic uses_rs2(input logic [31:0] ins);
        return ins[6:0] == 7'h23 || ins[6:0] == 7'h33 || ins[6:0] == 7'h63;
    endfunction

    function automatic logic haz_ref();
        if (!in_valid_i) return 1'b0;
        foreach (q[i])
            if (q[i].load && q[i].rd != 5'd0 &&
                ((uses_rs1(ins_i) && q[i].rd == ins_i[19:15]) || (uses_rs2(ins_i) && q[i].rd == ins_i[24:20])))
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic exp_t decode_ref(input logic [31:0] ins, addr, r1, r2, c);
        exp_t e;
        logic signed [11:0] i12 = ins[31:20];
        logic signed [11:0] s12 = {ins[31:25], ins[11:7]};
        logic signed [12:0] b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        logic signed [20:0] j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        e.ins = ins; e.addr = addr; e.r1 = r1; e.r2 = r2; e.c = c;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: e.imm = 32'(i12);
            7'h23:        e.imm = 32'(s12);
            7'h63:        e.imm = 32'(b13);
            7'h37, 7'h17: e.imm = ins & 32'hFFFFF000;
            7'h6F:        e.imm = 32'(j21);
            default:      e.imm = 32'd0;
        endcase
        if (ins[6:0] == 7'h23 || ins[6:0] == 7'h63 || (ins[6:0] == 7'h73 && ins[14:12] == 3'd0))
            e.rd = 5'd0;
        else
            e.rd = ins[11:7];
        e.maddr = r1 + e.imm;
        e.load  = (ins[6:0] == 7'h03);
        return e;
    endfunction

    // One clock: check handshake outputs, advance the model at the edge, check EX outputs.
    task automatic cycle();
        exp_t e;
        logic hz, rdy, rdy0, acc, acc0;
        #1;
        hz   = haz_ref();
        rdy  = (q.size() < 2) && !hz && !flush_i;
        rdy0 = (n0 < 2) && !flush_i;
        last_rdy = in_ready_o; last_hz = hazard_stall_o; last_rdy0 = n_in_ready_o;
        chk("in_ready", in_ready_o, rdy);
        chk("hazard_stall", hazard_stall_o, hz);
        chk("nl_in_ready", n_in_ready_o, rdy0);
        chk("nl_hazard_stall", n_hazard_stall_o, 0);
        chk("reg1_rd_addr", reg1_rd_addr_o, ins_i[19:15]);
        chk("reg2_rd_addr", reg2_rd_addr_o, ins_i[24:20]);
        chk("csr_rd_addr", csr_rd_addr_o, ins_i[31:20]);
        acc  = in_valid_i && rdy;
        acc0 = in_valid_i && rdy0;
        e    = decode_ref(ins_i, ins_addr_i, reg1_rd_data_i, reg2_rd_data_i, csr_rd_data_i);
        @(posedge clk);
        if (flush_i) begin
            q.delete();
            n0 = 0;
        end else begin
            if (q.size() > 0 && out_ready_i) void'(q.pop_front());
            if (acc) q.push_back(e);
            if (n0 > 0 && out_ready_i) n0--;
            if (acc0) n0++;
        end
        #1;
        chk("out_valid", out_valid_o, q.size() > 0);
        chk("nl_out_valid", n_out_valid_o, n0 > 0);
        chk("mem_rd_req", mem_rd_req_o, q.size() > 0 && q[0].load);
        if (q.size() > 0) begin
            chk("ins", ins_o, q[0].ins);
            chk("ins_addr", ins_addr_o, q[0].addr);
            chk("opcode", opcode_o, q[0].ins[6:0]);
            chk("funct3", funct3_o, q[0].ins[14:12]);
            chk("funct7", funct7_o, q[0].ins[31:25]);
            chk("rd", rd_o, q[0].rd);
            chk("rs1_data", rs1_data_o, q[0].r1);
            chk("rs2_data", rs2_data_o, q[0].r2);
            chk("csr_rd_data", csr_rd_data_o, q[0].c);
            chk("imm", imm_o, q[0].imm);
            chk("csr_addr", csr_addr_o, q[0].ins[31:20]);
            chk("csr_zimm", csr_zimm_o, {27'd0, q[0].ins[19:15]});
            chk("mem_rd_addr", mem_rd_addr_o, q[0].maddr);
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] r1, input logic ordy, input logic fl);
        in_valid_i     = v;
        ins_i          = ins;
        reg1_rd_data_i = r1;
        reg2_rd_data_i = $urandom;
        csr_rd_data_i  = $urandom;
        ins_addr_i     = $urandom;
        out_ready_i    = ordy;
        flush_i        = fl;
        cycle();
    endtask

    function automatic logic [31:0] rand_ins();
        logic [31:0] ins = $urandom;
        case ($urandom_range(0, 10))
            0: ins[6:0] = 7'h03;  1: ins[6:0] = 7'h13;  2: ins[6:0] = 7'h23;
            3: ins[6:0] = 7'h33;  4: ins[6:0] = 7'h37;  5: ins[6:0] = 7'h17;
            6: ins[6:0] = 7'h63;  7: ins[6:0] = 7'h67;  8: ins[6:0] = 7'h6F;
            9: ins[6:0] = 7'h73;  default: ins[6:0] = 7'h0B;
        endcase
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        return ins;
    endfunction

    localparam logic [31:0] ADDI_X5 = 32'hFFC08293;
    localparam logic [31:0] LW_X6   = 32'h00812303;
    localparam logic [31:0] ADD_X7  = 32'h001303B3;
    localparam logic [31:0] ADDI_A  = 32'h00100093;
    localparam logic [31:0] ADDI_B  = 32'h00200113;
    localparam logic [31:0] ADDI_C  = 32'h00300193;

    initial begin
        n0 = 0;
        rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        ins_i = '0; ins_addr_i = '0; reg1_rd_data_i = '0; reg2_rd_data_i = '0; csr_rd_data_i = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_ins", ins_o, 0);
        chk("rst_rd", rd_o, 0);
        chk("rst_imm", imm_o, 0);
        chk("rst_mem_rd_addr", mem_rd_addr_o, 0);
        rst_n = 1'b1;
        drive(0, 32'd0, 32'd0, 1, 0);

        drive(1, ADDI_X5, 32'h10, 1, 0);
        chk("addi_valid", out_valid_o, 1);
        chk("addi_rd", rd_o, 5);
        chk("addi_imm", imm_o, 32'hFFFFFFFC);
        chk("addi_memreq", mem_rd_req_o, 0);

        drive(1, LW_X6, 32'hFFFFFFFC, 1, 0);
        chk("lw_memreq", mem_rd_req_o, 1);
        chk("lw_wrap_addr", mem_rd_addr_o, 32'h4);

        // load-use: LW x6 sits in the buffer, ADD reads x6
        drive(1, ADD_X7, 32'h5, 0, 0);
        chk("luse_stall", last_hz, 1);
        chk("luse_blocked", last_rdy, 0);
        chk("nl_no_stall", last_rdy0, 1);
        drive(1, ADD_X7, 32'h5, 0, 0);
        chk("luse_still_stall", last_hz, 1);
        drive(1, ADD_X7, 32'h5, 1, 0);
        drive(1, ADD_X7, 32'h5, 1, 0);
        chk("luse_released", last_rdy, 1);
        repeat (3) drive(0, 32'd0, 32'd0, 1, 0);

        // back-pressure: two buffer, third waits, FIFO drain
        drive(1, ADDI_A, $urandom, 0, 0);
        drive(1, ADDI_B, $urandom, 0, 0);
        drive(1, ADDI_C, $urandom, 0, 0);
        chk("third_blocked", last_rdy, 0);
        chk("first_held", ins_o, ADDI_A);
        drive(1, ADDI_C, $urandom, 1, 0);
        chk("second_next", ins_o, ADDI_B);
        drive(1, ADDI_C, $urandom, 1, 0);
        chk("third_accepted", last_rdy, 1);
        chk("third_out", ins_o, ADDI_C);
        drive(0, 32'd0, 32'd0, 1, 0);

        // flush with two entries buffered and an incoming instruction
        drive(1, ADDI_A, $urandom, 0, 0);
        drive(1, ADDI_B, $urandom, 0, 0);
        drive(1, ADDI_C, $urandom, 0, 1);
        chk("flush_ready_low", last_rdy, 0);
        chk("flush_out_valid", out_valid_o, 0);
        drive(0, 32'd0, 32'd0, 1, 0);
        chk("post_flush_ready", last_rdy, 1);

        // asynchronous reset mid-stall
        drive(1, ADDI_A, $urandom, 0, 0);
        drive(1, ADDI_B, $urandom, 0, 0);
        in_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid_o, 0);
        chk("arst_nl_out_valid", n_out_valid_o, 0);
        chk("arst_ins", ins_o, 0);
        chk("arst_rd", rd_o, 0);
        chk("arst_memreq", mem_rd_req_o, 0);
        q.delete();
        n0 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive(0, 32'd0, 32'd0, 1, 0);
        chk("arst_ready_after", last_rdy, 1);

        for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 9) < 7, rand_ins(), $urandom, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 29) == 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/id_pipe_stage.md
Name: id_pipe_stage

Overview:
- Parametrised decode stage with a built-in 2-entry ID/EX skid buffer; successor to the single-register decode unit.
- Decodes a 32-bit RV32I/Zicsr instruction and issues GPR/CSR read addresses combinationally.
- Captures decoded fields plus operand data into a valid/ready-handshaked buffer feeding EX.
- Adds flush, load-use interlock and a registered load-address precompute (rs1+imm).

Parameters:
- XLEN, 32, GPR/CSR data width
- ADDR_W, 32, instruction/memory address width
- REG_AW, 5, GPR index width
- CSR_AW, 12, CSR address width
- LOAD_INTERLOCK, 1, 1 = stall on load-use hazard; 0 = never stall for hazards

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- flush_i  in  1  squash all buffered and incoming instructions
- in_valid_i  in  1  instruction from IF valid
- in_ready_o  out  1  ID accepts instruction this cycle
- ins_i  in  32  instruction
- ins_addr_i  in  ADDR_W  instruction address
- reg1_rd_addr_o  out  REG_AW  rs1 index, combinational from ins_i
- reg2_rd_addr_o  out  REG_AW  rs2 index, combinational from ins_i
- reg1_rd_data_i  in  XLEN  rs1 data, same cycle
- reg2_rd_data_i  in  XLEN  rs2 data, same cycle
- csr_rd_addr_o  out  CSR_AW  ins_i[31:20], combinational
- csr_rd_data_i  in  XLEN  CSR data, same cycle
- out_valid_o  out  1  EX entry valid
- out_ready_i  in  1  EX consumes entry
- ins_o, ins_addr_o  out  32/ADDR_W  buffered instruction and address
- opcode_o, funct3_o, funct7_o  out  7/3/7  decoded fields
- rd_o  out  REG_AW  destination index (0 if no writeback)
- rs1_data_o, rs2_data_o, csr_rd_data_o  out  XLEN  captured operands
- imm_o  out  XLEN  sign-extended immediate (I/S/B/U/J; 0 for R)
- csr_addr_o  out  CSR_AW  CSR address
- csr_zimm_o  out  XLEN  zero-extended ins[19:15]
- mem_rd_req_o  out  1  out_valid_o & entry is load
- mem_rd_addr_o  out  ADDR_W  rs1+imm, registered at capture
- hazard_stall_o  out  1  in_ready_o held low by load-use interlock

Behaviour:
- Reset is asynchronous and active-low (rst_n), with one clock clk.
  - All registered outputs are 0; out_valid_o = 0; both buffer entries are invalid.
  - in_ready_o = 1 from the first cycle after reset release.
- Buffer structure: main entry (drives outputs) plus a skid entry.
  - in_ready_o = !skid_valid & !hazard & !flush_i; it depends on registered state and flush_i only, never on out_ready_i.
- Accept: in_valid_i & in_ready_o.
  - Decoded fields and same-cycle read data are captured into main if main is empty or being consumed; otherwise into skid.
  - Latency from acceptance to out_valid_o is 1 cycle.
- Consume: out_valid_o & out_ready_i.
  - Skid moves to main on the same edge. Order is strictly FIFO.
  - Simultaneous accept and consume with skid valid cannot occur, because in_ready_o = 0 in that case.
- Stall: out_ready_i = 0 holds every output stable.
- Flush (flush_i = 1):
  - Both entries are invalidated on the next edge; out_valid_o = 0 the following cycle.
  - in_ready_o = 0 during the flush cycle, so nothing is accepted; it returns to 1 next cycle.
  - Flush has priority over accept and consume.
- rs1 is used by opcodes 0x03, 0x13, 0x23, 0x33, 0x63, 0x67, and by 0x73 when funct3[2] = 0 and funct3 ≠ 0. rs2 is used by 0x23, 0x33, 0x63.
- Load-use hazard (LOAD_INTERLOCK = 1):
  - Asserted when any valid buffer entry has opcode 0x03 and rd ≠ 0, and that rd equals a used rs of ins_i while in_valid_i = 1.
  - Effect: in_ready_o = 0 and hazard_stall_o = 1. Released once no matching load remains buffered.
  - Non-load RAW hazards are resolved by EX forwarding and are out of scope here.
- rd_o = 0 for opcodes 0x23, 0x63 and 0x73 with funct3 = 0.
- mem_rd_addr_o = (rs1_data + imm) truncated to ADDR_W; wraps modulo 2^ADDR_W with no overflow flag.
- An illegal or unknown opcode is passed through with imm = 0 and rd_o = ins[11:7]; EX raises the exception.
- Reset asserted mid-operation discards all entries immediately (asynchronous).

Test Plan:
- Single ADDI x5,x1,-4 (0xFFC08293), rs1_data 0x10, out_ready_i = 1 → next cycle out_valid_o = 1, rd_o = 5, imm_o = 0xFFFFFFFC, mem_rd_req_o = 0.
- LW x6,8(x2) with rs1_data 0xFFFFFFFC → mem_rd_req_o = 1, mem_rd_addr_o = 0x00000004 (wrap).
- Hold out_ready_i = 0 while feeding 3 instructions → first two buffered, in_ready_o = 0 on the third; release → they drain in order, then the third is accepted.
- LW x6 buffered, next ADD x7,x6,x1 → hazard_stall_o = 1 and in_ready_o = 0 until the LW is consumed; same case with LOAD_INTERLOCK = 0 → no stall.
- Two entries buffered, flush_i pulse with in_valid_i = 1 → out_valid_o = 0 next cycle, input dropped, in_ready_o = 1 after.
- rst_n low mid-stall → outputs 0 asynchronously; in_ready_o = 1 the cycle after release.
